alu_cmd_parser: RTL
===================

Name: alu_cmd_parser

Overview:
- Command/ALU stage between uart_rx (AXI-stream byte source) and uart_tx (AXI-stream byte sink) in the UART ALU design.
- Parses length-prefixed packets from the host and executes one of three commands: echo, 32-bit add, or 32-bit subtract.
- Echo forwards payload bytes to the transmitter; add/subtract return a 4-byte little-endian result.

Parameters:
- DATA_WIDTH, 8, stream byte width; only 8 is supported.
- OPERAND_WIDTH, 32, ALU operand/result width; only 32 is supported (4 bytes per operand).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- s_axis_tdata  input  8  byte from uart_rx
- s_axis_tvalid  input  1  upstream byte valid
- s_axis_tready  output  1  byte accepted when tvalid & tready
- m_axis_tdata  output  8  byte to uart_tx
- m_axis_tvalid  output  1  output byte valid
- m_axis_tready  input  1  uart_tx ready
- busy_o  output  1  high whenever state != OPCODE
- err_o  output  1  one-cycle pulse on a rejected header

Behaviour:
- Reset (rst_ni low, async): state=OPCODE; accumulator, counter and output register cleared; m_axis_tvalid=0, m_axis_tdata=0, err_o=0, busy_o=0; s_axis_tready forced 0 while rst_ni is low.
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2 len_lo, byte3 len_hi.
  - len = total packet bytes including the 4-byte header.
  - Payload = len-4 bytes.
- Opcodes:
  - 0xEC ECHO.
  - 0xAD ADD: sum of all operands mod 2^32.
  - 0x5B SUB: first operand minus each subsequent operand, mod 2^32.
  - Operands are 4 bytes, little-endian.
- States: OPCODE, RSV, LEN_LO, LEN_HI, ECHO, ACCUM, SEND, DRAIN.
- Header states: s_axis_tready=1; each accepted byte advances one state.
- Header check, at acceptance of the len_hi byte:
  - len<4: err_o pulse next cycle, go to OPCODE.
  - Unknown opcode, or ADD/SUB with payload zero or not a multiple of 4: err_o pulse; go to DRAIN if payload>0, else OPCODE.
  - ECHO with payload=0: go to OPCODE, no output, no error.
  - Otherwise: load 16-bit remaining counter = len-4; go to ECHO or ACCUM.
- ECHO:
  - Single-entry output register; s_axis_tready = !m_axis_tvalid | m_axis_tready.
  - A byte accepted in cycle N drives m_axis_tdata/tvalid in cycle N+1.
  - Counter decrements per accepted byte; after the last byte, go to OPCODE. The already-loaded final output byte still completes its handshake while header parsing resumes.
- ACCUM:
  - s_axis_tready=1; bytes assembled LSB first into a 32-bit operand shift register.
  - On the 4th byte of each operand:
    - First operand: accumulator = operand (both ADD and SUB).
    - Later operands: accumulator += operand (ADD) or -= operand (SUB).
    - Carry/borrow is discarded.
  - On the last payload byte, the final operand is folded in the same cycle; go to SEND.
- SEND:
  - s_axis_tready=0; m_axis_tvalid=1 beginning the cycle after the last payload byte.
  - Bytes sent acc[7:0], acc[15:8], acc[23:16], acc[31:24].
  - Index advances only on m_axis_tvalid & m_axis_tready; tdata/tvalid held stable while stalled.
  - After the 4th handshake: m_axis_tvalid=0 next cycle; go to OPCODE.
- DRAIN: s_axis_tready=1; discard the remaining payload bytes with no output; go to OPCODE after the count reaches 0.
- Throughput: no dead cycles between packets; s_axis_tvalid gaps at any point are tolerated.
- err_o: asserted exactly one cycle per rejected packet, never otherwise.
- Reset mid-packet: immediate return to the reset state. Partial results and pending output bytes are lost.

Test Plan:
- Echo: EC 00 07 00 41 42 43 -> m_axis emits 41,42,43 in order; busy_o low after; err_o never high.
- ADD with wrap: AD 00 0C 00 01 00 00 00 FF FF FF FF -> emits 00 00 00 00. Then AD 00 0C 00 05 00 00 00 07 00 00 00 -> emits 0C 00 00 00.
- SUB: 5B 00 10 00 0A 00 00 00 03 00 00 00 09 00 00 00 -> emits FE FF FF FF (10-3-9 = -2).
- Errors:
  - 77 00 06 00 AA BB -> err_o one pulse, no output, both payload bytes consumed.
  - Following EC 00 05 00 5A -> emits 5A.
  - AD 00 06 00 11 22 -> err_o pulse, drained.
- Backpressure: ADD result sent with m_axis_tready toggling randomly (50%) -> bytes and order unchanged, tdata stable while stalled, s_axis_tready=0 throughout SEND. Echo with m_axis_tready=0 for 10 cycles -> no byte lost or duplicated.
- Reset: pulse rst_ni low after AD 00 0C 00 01 02 -> outputs reset immediately. Then EC 00 05 00 33 -> emits 33.

Source files
------------

// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser: parses length-prefixed host packets and runs echo, 32-bit add or 32-bit subtract
module alu_cmd_parser #(
  parameter int DATA_WIDTH = 8,
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  err_o
);
  typedef enum logic [2:0] {OPCODE, RSV, LEN_LO, LEN_HI, ECHO, ACCUM, SEND, DRAIN} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] opc, len_lo, out_data;
  logic [15:0] len, pay, cnt;
  logic [OPERAND_WIDTH-1:0] acc, opnd, word;
  logic [1:0] bidx, idx;
  logic first, out_valid, s_hs, last, is_echo, is_alu, bad, rej, send_hs;
  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign len     = {s_axis_tdata, len_lo};
  assign pay     = len - 16'd4;
  assign is_echo = opc == 8'hEC;
  assign is_alu  = (opc == 8'hAD) || (opc == 8'h5B);
  assign bad     = len < 16'd4;
  assign rej     = (!is_echo && !is_alu) || (is_alu && ((pay == 16'd0) || (pay[1:0] != 2'd0)));
  assign last    = cnt == 16'd1;
  assign word    = {s_axis_tdata, opnd[OPERAND_WIDTH-1:DATA_WIDTH]};
  // a leftover echo byte is flushed before the result bytes are presented
  assign send_hs = (state == SEND) && !out_valid && m_axis_tready;
  assign s_axis_tready = rst_ni && ((state == ECHO) ? (!out_valid || m_axis_tready) : (state != SEND));
  assign m_axis_tvalid = out_valid || (state == SEND);
  assign m_axis_tdata  = ((state == SEND) && !out_valid) ? acc[{idx, 3'b000} +: DATA_WIDTH] : out_data;
  assign busy_o = state != OPCODE;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= OPCODE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      OPCODE: state_n = s_hs ? RSV : OPCODE;
      RSV:    state_n = s_hs ? LEN_LO : RSV;
      LEN_LO: state_n = s_hs ? LEN_HI : LEN_LO;
      LEN_HI: if (s_hs) state_n = bad ? OPCODE : rej ? ((pay != 16'd0) ? DRAIN : OPCODE) :
                                  (pay == 16'd0) ? OPCODE : is_echo ? ECHO : ACCUM;
      ECHO, DRAIN: state_n = (s_hs && last) ? OPCODE : state;
      ACCUM:  state_n = (s_hs && last) ? SEND : ACCUM;
      SEND:   state_n = (send_hs && idx == 2'd3) ? OPCODE : SEND;
      default: state_n = OPCODE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      opc <= '0;
      len_lo <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      bidx <= '0;
      idx <= '0;
      first <= 1'b0;
      err_o <= 1'b0;
    end else begin
      err_o <= s_hs && (state == LEN_HI) && (bad || rej);
      if (s_hs && state == OPCODE) opc <= s_axis_tdata;
      if (s_hs && state == LEN_LO) len_lo <= s_axis_tdata;
      if (s_hs && state == LEN_HI) begin
        cnt <= pay;
        first <= 1'b1;
        bidx <= '0;
      end
      if (s_hs && (state == ECHO || state == ACCUM || state == DRAIN)) cnt <= cnt - 16'd1;
      if (s_hs && state == ACCUM) begin
        opnd <= word;
        bidx <= bidx + 2'd1;
        if (bidx == 2'd3) begin
          acc <= first ? word : (opc == 8'h5B) ? acc - word : acc + word;
          first <= 1'b0;
        end
      end
      if (send_hs) idx <= idx + 2'd1;
      if (s_hs && state == ECHO) begin
        out_data <= s_axis_tdata;
        out_valid <= 1'b1;
      end else if (m_axis_tready) out_valid <= 1'b0;
    end
endmodule
